nios_pio_in_capture: RTL and testbench



---
 rtl/nios_pio_in_capture.sv | 153 +++++++++++++++
 tb/tb_nios_pio_in_capture.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/nios_pio_in_capture.sv
// ---------------------------------------------------------------------------
// nios_pio_in_capture
//
// Avalon-MM slave input port for the Nios bus. It is the read-side partner of
// the single-bit output PIOs. WIDTH asynchronous input pins pass through a
// two-flop synchroniser, and their level can be read back. Selected edges set
// sticky bits in a capture register. Software clears those bits by writing 1
// to them. Any captured bit that is also enabled in irq_mask drives a level
// interrupt.
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous, active-low reset
//   address     Avalon word address:
//                 0 DATA, 1 reserved, 2 IRQ_MASK, 3 EDGE_CAPTURE
//   chipselect  slave select
//   read_n      read strobe, active-low
//   write_n     write strobe, active-low
//   writedata   write data; only the low WIDTH bits are used
//   readdata    registered read data, valid one cycle after an accepted read
//   in_port     asynchronous external inputs
//   irq         active-high level interrupt, |(edge_capture & irq_mask)
// ---------------------------------------------------------------------------
module nios_pio_in_capture #(
    parameter int          WIDTH      = 8,
    parameter int          EDGE_TYPE  = 0,
    parameter logic [31:0] RESET_MASK = 32'h0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_sel;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] w1c_bits;
    logic [1:0]       arm_cnt;
    logic             armed;
    logic             wr_en;
    logic             rd_en;
    logic [31:0]      read_mux;
    logic             unused_wdata;

    assign wr_en = chipselect & ~write_n;
    assign rd_en = chipselect & ~read_n;

    // Only the low WIDTH bits of writedata are used. This reduction marks the
    // upper bits as intentionally unused.
    assign unused_wdata = ^writedata;

    // Two-flop synchroniser. prev holds the previous synchronised level so
    // that the edge detector compares two stable samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // Arm counter. It saturates at 2 after reset, and detection opens one
    // cycle after that. By then prev has taken a real synchronised sample.
    // Pins that are already high when reset releases are therefore seen as
    // a level and not as a rising edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arm_cnt <= 2'd0;
            armed   <= 1'b0;
        end else begin
            if (arm_cnt != 2'd2) begin
                arm_cnt <= arm_cnt + 2'd1;
            end
            armed <= (arm_cnt == 2'd2);
        end
    end

    // Edge selection. EDGE_TYPE 0 captures rising edges, 1 captures falling
    // edges, and any other value captures both.
    always_comb begin
        rise = sync2 & ~prev;
        fall = ~sync2 & prev;
        case (EDGE_TYPE)
            0:       edge_sel = rise;
            1:       edge_sel = fall;
            default: edge_sel = rise | fall;
        endcase
        edge_det = armed ? edge_sel : '0;
    end

    assign w1c_bits = (wr_en && (address == 2'd3)) ? writedata[WIDTH-1:0] : '0;

    // Sticky capture register. The clear is applied before the OR with new
    // edges. If a new edge arrives in the same cycle as a clear, the bit
    // stays set and the event is not lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_capture <= '0;
        end else begin
            edge_capture <= (edge_capture & ~w1c_bits) | edge_det;
        end
    end

    // Interrupt mask register. It is the only plain read/write register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask <= RESET_MASK[WIDTH-1:0];
        end else if (wr_en && (address == 2'd2)) begin
            irq_mask <= writedata[WIDTH-1:0];
        end
    end

    // Read multiplexer. Bits above WIDTH and the reserved word read as zero.
    always_comb begin
        read_mux = '0;
        case (address)
            2'd0: read_mux[WIDTH-1:0] = sync2;
            2'd1: read_mux = '0;
            2'd2: read_mux[WIDTH-1:0] = irq_mask;
            2'd3: read_mux[WIDTH-1:0] = edge_capture;
        endcase
    end

    // readdata is captured from the current register state. A read that
    // shares a cycle with a write therefore returns the value before the write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else if (rd_en) begin
            readdata <= read_mux;
        end
    end

    assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_nios_pio_in_capture.sv
// ---------------------------------------------------------------------------
// tb_nios_pio_in_capture
//
// Self-checking bench for nios_pio_in_capture. There are three instances,
// one each for rising, falling and any-edge capture. They share the bus and
// in_port. Every read pushes the expected readdata of each instance into a
// scoreboard queue. When readdata becomes valid the entries are popped and
// compared.
// ---------------------------------------------------------------------------
module tb_nios_pio_in_capture;

    typedef struct {
        string       tag;
        int          which;
        logic [31:0] value;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] rd_rise;
    logic [31:0] rd_fall;
    logic [31:0] rd_any;
    logic        irq_rise;
    logic        irq_fall;
    logic        irq_any;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    nios_pio_in_capture #(.WIDTH(8), .EDGE_TYPE(0), .RESET_MASK(32'h0)) dut_rise (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .read_n(read_n), .write_n(write_n), .writedata(writedata),
        .readdata(rd_rise), .in_port(in_port), .irq(irq_rise)
    );

    nios_pio_in_capture #(.WIDTH(8), .EDGE_TYPE(1), .RESET_MASK(32'h0)) dut_fall (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .read_n(read_n), .write_n(write_n), .writedata(writedata),
        .readdata(rd_fall), .in_port(in_port), .irq(irq_fall)
    );

    nios_pio_in_capture #(.WIDTH(8), .EDGE_TYPE(2), .RESET_MASK(32'h0)) dut_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .read_n(read_n), .write_n(write_n), .writedata(writedata),
        .readdata(rd_any), .in_port(in_port), .irq(irq_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if observed and expected differ.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] pick_rd(input int which);
        case (which)
            0:       return rd_rise;
            1:       return rd_fall;
            default: return rd_any;
        endcase
    endfunction

    // Drive in_port and let the given number of clock edges pass. The task
    // returns 1 time unit after the last edge.
    task automatic applyStimulus(input logic [7:0] value, input int cycles);
        in_port = value;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One bus cycle. After the edge, pending scoreboard entries are popped
    // and compared with the registered readdata.
    task automatic drive_bus(input logic [1:0] addr, input bit rd, input bit wr,
                             input logic [31:0] wdata);
        exp_t e;
        address    = addr;
        chipselect = 1'b1;
        read_n     = ~rd;
        write_n    = ~wr;
        writedata  = wdata;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        read_n     = 1'b1;
        write_n    = 1'b1;
        writedata  = '0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput(e.tag, pick_rd(e.which), e.value);
        end
    endtask

    task automatic push_exp(input string tag, input logic [31:0] e_rise,
                            input logic [31:0] e_fall, input logic [31:0] e_any);
        exp_q.push_back('{tag: {tag, "_rise"}, which: 0, value: e_rise});
        exp_q.push_back('{tag: {tag, "_fall"}, which: 1, value: e_fall});
        exp_q.push_back('{tag: {tag, "_any"},  which: 2, value: e_any});
    endtask

    task automatic bus_read(input logic [1:0] addr, input string tag,
                            input logic [31:0] e_rise, input logic [31:0] e_fall,
                            input logic [31:0] e_any);
        push_exp(tag, e_rise, e_fall, e_any);
        drive_bus(addr, 1'b1, 1'b0, '0);
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        drive_bus(addr, 1'b0, 1'b1, data);
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        read_n     = 1'b1;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 8'hFF;

        // Reset state, with inputs high through release
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_readdata", rd_rise, 32'h0);
        checkOutput("rst_irq", 32'(irq_rise), 32'h0);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(8'hFF, 10);
        checkOutput("t1_irq", 32'(irq_rise), 32'h0);
        bus_read(2'd3, "t1_cap", 32'h0, 32'h0, 32'h0);
        bus_read(2'd0, "t1_data", 32'hFF, 32'hFF, 32'hFF);

        // Drop all inputs and clear whatever the falling/any units caught
        applyStimulus(8'h00, 4);
        bus_write(2'd3, 32'hFF);
        bus_read(2'd3, "prep_cap", 32'h0, 32'h0, 32'h0);

        // Rising edge on bit 0: captured after edge k+2, not k+1
        bus_write(2'd2, 32'h01);
        applyStimulus(8'h01, 2);
        checkOutput("t2_irq_k1", 32'(irq_rise), 32'h0);
        applyStimulus(8'h01, 1);
        checkOutput("t2_irq_k2", 32'(irq_rise), 32'h1);
        checkOutput("t2_irq_fall", 32'(irq_fall), 32'h0);
        bus_read(2'd3, "t2_cap", 32'h1, 32'h0, 32'h1);
        applyStimulus(8'h01, 2);
        checkOutput("t2_hold", rd_rise, 32'h1);

        // Write-1-to-clear
        bus_write(2'd3, 32'h1);
        checkOutput("t3_irq_clr", 32'(irq_rise), 32'h0);
        bus_read(2'd3, "t3_clr", 32'h0, 32'h0, 32'h0);

        // A clear in the same cycle as a new capture: the edge wins
        applyStimulus(8'h00, 4);
        bus_write(2'd3, 32'hFF);
        applyStimulus(8'h01, 2);
        bus_write(2'd3, 32'h1);
        checkOutput("t3_collide_irq", 32'(irq_rise), 32'h1);
        bus_read(2'd3, "t3_collide", 32'h1, 32'h0, 32'h1);
        bus_write(2'd3, 32'hFF);
        bus_read(2'd3, "t3_clean", 32'h0, 32'h0, 32'h0);

        // Multi-bit capture, masking, upper writedata bits and address decode
        applyStimulus(8'h00, 4);
        bus_write(2'd2, 32'h0);
        bus_write(2'd3, 32'hFF);
        applyStimulus(8'hA5, 3);
        checkOutput("t4_irq_masked", 32'(irq_rise), 32'h0);
        bus_read(2'd3, "t4_cap", 32'hA5, 32'h0, 32'hA5);
        bus_write(2'd2, 32'hFFFF_FF04);
        checkOutput("t4_unmask", 32'(irq_rise), 32'h1);
        bus_read(2'd2, "t4_mask", 32'h04, 32'h04, 32'h04);
        bus_write(2'd3, 32'hFF);
        checkOutput("t4_irq_clr", 32'(irq_rise), 32'h0);
        bus_read(2'd3, "t4_clr", 32'h0, 32'h0, 32'h0);
        bus_write(2'd1, 32'hFFFF_FFFF);
        bus_write(2'd0, 32'h0);
        bus_read(2'd1, "t4_rsvd", 32'h0, 32'h0, 32'h0);
        bus_read(2'd0, "t4_data", 32'hA5, 32'hA5, 32'hA5);
        push_exp("t4_rw_pre", 32'h04, 32'h04, 32'h04);
        drive_bus(2'd2, 1'b1, 1'b1, 32'h80);
        bus_read(2'd2, "t4_rw_post", 32'h80, 32'h80, 32'h80);

        // Four-cycle pulse on bit 3 for the falling and any-edge units
        applyStimulus(8'h00, 4);
        bus_write(2'd3, 32'hFF);
        bus_write(2'd2, 32'h08);
        applyStimulus(8'h08, 4);
        checkOutput("t5_fall_pre", 32'(irq_fall), 32'h0);
        checkOutput("t5_any_rise", 32'(irq_any), 32'h1);
        applyStimulus(8'h00, 4);
        checkOutput("t5_fall_post", 32'(irq_fall), 32'h1);
        bus_read(2'd3, "t5_cap", 32'h08, 32'h08, 32'h08);

        // Asynchronous reset while captures are pending
        bus_write(2'd2, 32'hFF);
        applyStimulus(8'hFF, 3);
        checkOutput("t6_irq_pre", 32'(irq_rise), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("t6_irq_async", 32'(irq_rise), 32'h0);
        checkOutput("t6_irq_any_async", 32'(irq_any), 32'h0);
        checkOutput("t6_rd_async", rd_rise, 32'h0);
        repeat (2) @(posedge clk);
        #4 reset_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            bus_read(2'd3, $sformatf("t6_noarm%0d", i), 32'h0, 32'h0, 32'h0);
        end
        bus_read(2'd2, "t6_mask", 32'h0, 32'h0, 32'h0);
        bus_read(2'd0, "t6_data", 32'hFF, 32'hFF, 32'hFF);
        applyStimulus(8'h7F, 4);
        applyStimulus(8'hFF, 4);
        bus_read(2'd3, "t6_rearm", 32'h80, 32'h80, 32'h80);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
